// File: rtl/bcd_updown_counter.sv
// N-digit registered BCD up/down counter with validated parallel load,
// wrap or saturate limits, and one-cycle carry/borrow/load_err pulses
// suitable for cascading stages.
module bcd_updown_counter #(
    parameter int N_DIGITS = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  en,
    input  logic                  up,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  carry,
    output logic                  borrow,
    output logic                  load_err,
    output logic                  at_max,
    output logic                  at_min
);

    localparam int W = 4 * N_DIGITS;

    logic [W-1:0] cnt;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         inc_c;
    logic         dec_b;
    logic         all_nines;
    logic         all_zeros;
    logic         load_ok;

    // Ripple increment/decrement across digits and detect the limit values.
    always_comb begin
        inc_val   = cnt;
        dec_val   = cnt;
        inc_c     = 1'b1;
        dec_b     = 1'b1;
        all_nines = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (inc_c) begin
                if (cnt[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    inc_c = 1'b0;
                end
            end
            if (dec_b) begin
                if (cnt[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
                    dec_b = 1'b0;
                end
            end
            if (cnt[4*i +: 4] != 4'd9) all_nines = 1'b0;
            if (cnt[4*i +: 4] != 4'd0) all_zeros = 1'b0;
        end
    end

    // A load is accepted only when every incoming digit is a legal BCD value.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    // Count register and pulse flags; clr beats load beats en on each edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (load) begin
                if (load_ok) begin
                    cnt <= bcd_in;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (up) begin
                    if (all_nines) begin
                        carry <= 1'b1;
                        if (!SATURATE) cnt <= '0;
                    end else begin
                        cnt <= inc_val;
                    end
                end else begin
                    if (all_zeros) begin
                        borrow <= 1'b1;
                        if (!SATURATE) cnt <= {N_DIGITS{4'd9}};
                    end else begin
                        cnt <= dec_val;
                    end
                end
            end
        end
    end

    assign bcd_out = cnt;
    assign at_max  = all_nines;
    assign at_min  = all_zeros;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a 3-digit wrap instance, a 3-digit
// saturating instance and a 2-digit wrap instance share one control stream.
module tb_bcd_updown_counter;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        load;
    logic        en;
    logic        up;
    logic [11:0] bcd_in;
    logic [7:0]  bcd_in2;

    logic [11:0] w_out, s_out;
    logic [7:0]  t_out;
    logic        w_carry, w_borrow, w_lerr, w_max, w_min;
    logic        s_carry, s_borrow, s_lerr, s_max, s_min;
    logic        t_carry, t_borrow, t_lerr, t_max, t_min;

    int n_vec;
    int n_err;
    logic [7:0] exp_q[$];

    assign bcd_in2 = bcd_in[7:0];

    bcd_updown_counter #(.N_DIGITS(3), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .bcd_in(bcd_in),
        .en(en), .up(up), .bcd_out(w_out), .carry(w_carry), .borrow(w_borrow),
        .load_err(w_lerr), .at_max(w_max), .at_min(w_min)
    );

    bcd_updown_counter #(.N_DIGITS(3), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .bcd_in(bcd_in),
        .en(en), .up(up), .bcd_out(s_out), .carry(s_carry), .borrow(s_borrow),
        .load_err(s_lerr), .at_max(s_max), .at_min(s_min)
    );

    bcd_updown_counter #(.N_DIGITS(2), .SATURATE(1'b0)) u_two (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .bcd_in(bcd_in2),
        .en(en), .up(up), .bcd_out(t_out), .carry(t_carry), .borrow(t_borrow),
        .load_err(t_lerr), .at_max(t_max), .at_min(t_min)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic idle();
        clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [11:0] v);
        idle(); load = 1'b1; bcd_in = v;
        tick();
        idle();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // directed steps
    initial begin
        int carries;
        int borrows;
        int v;
        logic [7:0] e;
        n_vec = 0; n_err = 0;
        idle(); bcd_in = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(w_out), 32'h000);
        chk("reset_min", 32'(w_min), 32'd1);
        chk("reset_max", 32'(w_max), 32'd0);
        chk("reset_pulses", 32'({w_carry, w_borrow, w_lerr}), 32'd0);
        #3 reset = 1'b0;
        tick();
        chk("hold_after_reset", 32'(w_out), 32'h000);

        // increment with ripple
        do_load(12'h259);
        chk("load_259", 32'(w_out), 32'h259);
        en = 1'b1; up = 1'b1; tick(); idle();
        chk("inc_259", 32'(w_out), 32'h260);
        chk("inc_259_carry", 32'(w_carry), 32'd0);

        // wrap vs saturate at all-9s, three increments
        do_load(12'h999);
        chk("load_999_max", 32'(w_max), 32'd1);
        en = 1'b1; up = 1'b1;
        tick();
        chk("wrap_999", 32'(w_out), 32'h000);
        chk("wrap_999_carry", 32'(w_carry), 32'd1);
        chk("sat_999_a", 32'(s_out), 32'h999);
        chk("sat_carry_a", 32'(s_carry), 32'd1);
        tick();
        chk("wrap_001", 32'(w_out), 32'h001);
        chk("wrap_001_carry", 32'(w_carry), 32'd0);
        chk("sat_999_b", 32'(s_out), 32'h999);
        chk("sat_carry_b", 32'(s_carry), 32'd1);
        tick(); idle();
        chk("wrap_002", 32'(w_out), 32'h002);
        chk("sat_999_c", 32'(s_out), 32'h999);
        chk("sat_carry_c", 32'(s_carry), 32'd1);
        tick();
        chk("sat_carry_drop", 32'(s_carry), 32'd0);

        // decrement with borrow ripple and wrap
        do_load(12'h100);
        en = 1'b1; up = 1'b0; tick(); idle();
        chk("dec_100", 32'(w_out), 32'h099);
        chk("dec_100_borrow", 32'(w_borrow), 32'd0);
        do_load(12'h000);
        en = 1'b1; up = 1'b0; tick(); idle();
        chk("dec_000", 32'(w_out), 32'h999);
        chk("dec_000_borrow", 32'(w_borrow), 32'd1);
        chk("sat_dec_000", 32'(s_out), 32'h000);
        chk("sat_dec_borrow", 32'(s_borrow), 32'd1);
        chk("sat_dec_min", 32'(s_min), 32'd1);
        tick();
        chk("borrow_drop", 32'({w_borrow, s_borrow}), 32'd0);

        // asynchronous reset mid-count
        do_load(12'h456);
        en = 1'b1; up = 1'b1; tick(); tick();
        chk("pre_reset_count", 32'(w_out), 32'h458);
        idle();
        #3 reset = 1'b1;
        #1;
        chk("async_reset_out", 32'(w_out), 32'h000);
        chk("async_reset_min", 32'(w_min), 32'd1);
        #2 reset = 1'b0;
        tick();
        chk("post_reset_hold", 32'(w_out), 32'h000);

        // load validation
        do_load(12'h321);
        do_load(12'h2A5);
        chk("bad_load_out", 32'(w_out), 32'h321);
        chk("bad_load_err", 32'(w_lerr), 32'd1);
        tick();
        chk("bad_load_err_drop", 32'(w_lerr), 32'd0);

        // priority
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; bcd_in = 12'h555;
        tick(); idle();
        chk("clr_priority", 32'(w_out), 32'h000);
        load = 1'b1; en = 1'b1; up = 1'b1; bcd_in = 12'h123;
        tick(); idle();
        chk("load_over_en", 32'(w_out), 32'h123);

        // 2-digit sweep up then down
        clr = 1'b1; tick(); idle();
        chk("sweep_start", 32'(t_out), 32'h00);
        carries = 0;
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            exp_q.push_back(to_bcd2(i % 100));
            tick();
            e = exp_q.pop_front();
            chk("sweep_up", 32'(t_out), 32'(e));
            chk("sweep_up_carry", 32'(t_carry), (i == 100) ? 32'd1 : 32'd0);
            if (t_carry) carries++;
            if (i == 99) chk("sweep_at_max", 32'(t_max), 32'd1);
        end
        chk("sweep_carry_count", 32'(carries), 32'd1);
        borrows = 0;
        up = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            v = (100 - i) % 100;
            exp_q.push_back(to_bcd2(v));
            tick();
            e = exp_q.pop_front();
            chk("sweep_dn", 32'(t_out), 32'(e));
            chk("sweep_dn_borrow", 32'(t_borrow), (i == 1) ? 32'd1 : 32'd0);
            if (t_borrow) borrows++;
        end
        idle();
        chk("sweep_borrow_count", 32'(borrows), 32'd1);
        chk("sweep_end_min", 32'(t_min), 32'd1);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
